// File: rtl/ws2812b_line_encoder.sv
// ----------------------------------------------------------------------------
// ws2812b_line_encoder
//
// Turns a handshaked stream of pixel bits into the WS2812B single-wire NRZ
// waveform. Every accepted bit occupies one TBIT_CYC-long slot. The slot
// starts with a high phase of T1H_CYC clocks for a '1' or T0H_CYC clocks for
// a '0', and the line stays low for the rest of the slot. When no bit is
// waiting at the end of a slot, the line is held low for TRESET_CYC clocks so
// the LEDs latch the frame.
//
// Ports
//   clock      in  : the only clock, rising edge
//   reset      in  : synchronous, active-high reset
//   bit_in     in  : data bit from upstream, sampled only while bit_ack=1
//   bit_valid  in  : upstream has a bit ready
//   bit_ack    out : one-cycle pulse, bit_in is consumed this cycle
//   dout       out : registered WS2812B data line
//   busy       out : high whenever the encoder is not idle
//   frame_done out : one-cycle pulse on the last cycle of the latch period
//
// Build option
//   WS2812B_INVERT_OUTPUT_EN : when defined, dout carries the complement of
//   the line so that an inverting level shifter can be used. Only the pin
//   polarity changes. The timing is the same.
// ----------------------------------------------------------------------------
module ws2812b_line_encoder #(
  parameter int unsigned T0H_CYC    = 20,
  parameter int unsigned T1H_CYC    = 40,
  parameter int unsigned TBIT_CYC   = 63,
  parameter int unsigned TRESET_CYC = 2600
) (
  input  logic clock,
  input  logic reset,
  input  logic bit_in,
  input  logic bit_valid,
  output logic bit_ack,
  output logic dout,
  output logic busy,
  output logic frame_done
);

  // Pin levels for the two line states.
`ifdef WS2812B_INVERT_OUTPUT_EN
  localparam logic C_PIN_LOW  = 1'b1;
`else
  localparam logic C_PIN_LOW  = 1'b0;
`endif
  localparam logic C_PIN_HIGH = ~C_PIN_LOW;

  localparam logic [15:0] C_T0H         = 16'(T0H_CYC);
  localparam logic [15:0] C_T1H         = 16'(T1H_CYC);
  localparam logic [15:0] C_TBIT_LAST   = 16'(TBIT_CYC - 1);
  localparam logic [15:0] C_TRESET_LAST = 16'(TRESET_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_LATCH
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_hi_len;
  logic        r_dout;
  logic        r_busy;

  logic        w_slot_end;
  logic        w_hi_end;
  logic        w_latch_end;
  logic        w_capture;
  logic [15:0] w_hi_len_next;

  // Decode the timing events from the registered state and counter.
  always_comb begin
    w_slot_end    = (r_state == S_LOW)   && (r_cnt == C_TBIT_LAST);
    w_hi_end      = (r_state == S_HIGH)  && (r_cnt == (r_hi_len - 16'd1));
    w_latch_end   = (r_state == S_LATCH) && (r_cnt == C_TRESET_LAST);
    // There are exactly two capture points: in IDLE, and on the last cycle
    // of a LOW phase. Reset overrides both, so a bit is never acknowledged
    // while it is being discarded.
    w_capture     = !reset && bit_valid && ((r_state == S_IDLE) || w_slot_end);
    w_hi_len_next = bit_in ? C_T1H : C_T0H;
  end

  assign bit_ack    = w_capture;
  assign frame_done = w_latch_end && !reset;
  assign dout       = r_dout;
  assign busy       = r_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi_len <= C_T0H;
      r_dout   <= C_PIN_LOW;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_capture) begin
            r_state  <= S_HIGH;
            r_hi_len <= w_hi_len_next;
            r_dout   <= C_PIN_HIGH;
            r_busy   <= 1'b1;
          end
        end

        S_HIGH: begin
          // The counter keeps running into LOW, so the slot length is
          // measured from the rising edge and does not depend on hi_len.
          r_cnt <= r_cnt + 16'd1;
          if (w_hi_end) begin
            r_state <= S_LOW;
            r_dout  <= C_PIN_LOW;
          end
        end

        S_LOW: begin
          if (w_slot_end) begin
            r_cnt <= '0;
            if (w_capture) begin
              r_state  <= S_HIGH;
              r_hi_len <= w_hi_len_next;
              r_dout   <= C_PIN_HIGH;
            end else begin
              r_state <= S_LATCH;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_LATCH: begin
          if (w_latch_end) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_dout  <= C_PIN_LOW;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
